unidade_controle_rodadas: RTL
=============================

Name: unidade_controle_rodadas

Overview:
- Parametrised successor of the single-pass game control unit.
- Runs a growing-sequence game: round k requires k+1 correct plays, from address 0 to address k.
- Owns the address counter, round counter and an optional inactivity timeout. Drives the datapath's play register and memory address.
- Sits between the top-level game module and the datapath (memory, comparator, play register).

Parameters:
ADDR_WIDTH, 4, width of endereco/rodada; game has 2^ADDR_WIDTH rounds
TIMEOUT, 3000, clock cycles allowed in espera before timeout (must be >=2)
TIMER_WIDTH, 12, width of internal timeout counter (2^TIMER_WIDTH > TIMEOUT)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
iniciar  in  1  start/restart request
jogada  in  1  one-cycle pulse: player made a play
igual  in  1  datapath comparator: registered play equals memory[endereco]
modo  in  1  1 = timeout enabled, 0 = no timeout
zeraR  out  1  clear play register
registraR  out  1  load play register
endereco  out  ADDR_WIDTH  memory address of expected play
rodada  out  ADDR_WIDTH  current round index (0-based)
acertou  out  1  game won
errou  out  1  wrong play
timeout  out  1  game ended by inactivity
pronto  out  1  game finished (any outcome)
db_estado  out  4  state code for debug display

Behaviour:
- Reset (reset=0, async): state=inicial, endereco=0, rodada=0, timer=0. Outputs are decoded from state: zeraR=1, all other 1-bit outputs 0, db_estado=0.
- All 1-bit outputs are Moore: combinational decode of the registered state.
- endereco, rodada and timer are registers updated on the clock edge according to the current state.
- States, with db_estado code, action and transition:
  - inicial (0): zeraR=1. iniciar -> preparacao.
  - preparacao (1): zeraR=1; endereco<=0, rodada<=0. -> inicia_rodada.
  - inicia_rodada (2): endereco<=0, timer<=0. -> espera.
  - espera (3):
    - jogada -> registra; timer<=0.
    - else if modo=1 and timer==TIMEOUT-1 -> fim_timeout.
    - else stay; timer<=timer+1 (only when modo=1; otherwise the timer holds).
  - registra (4): registraR=1. -> comparacao.
  - comparacao (5):
    - igual=0 -> fim_erro.
    - igual=1 and endereco!=rodada -> proximo.
    - igual=1 and endereco==rodada and rodada!=all-ones -> proxima_rodada.
    - igual=1 and endereco==rodada==all-ones -> fim_acerto.
  - proximo (6): endereco<=endereco+1, timer<=0. -> espera.
  - proxima_rodada (7): rodada<=rodada+1. -> inicia_rodada.
  - fim_acerto (A): pronto=1, acertou=1. iniciar -> preparacao.
  - fim_erro (E): pronto=1, errou=1. iniciar -> preparacao.
  - fim_timeout (D): pronto=1, timeout=1. iniciar -> preparacao.
  - Unused codes: db_estado=F, next state inicial.
- Boundary rules:
  - jogada and timeout expiry in the same cycle: jogada wins.
  - jogada outside espera: ignored.
  - iniciar outside inicial and the fim_* states: ignored.
  - Counters never wrap; rodada all-ones is terminal via fim_acerto.
  - modo is sampled every cycle; dropping modo mid-wait freezes the timer.
  - Reset mid-game returns to inicial immediately, regardless of clock.
- Latency:
  - Play accepted to verdict: 2 cycles (registra, comparacao).
  - Round boundary: 2 cycles (proxima_rodada, inicia_rodada) before espera.
- Timeout fires exactly TIMEOUT cycles after entering espera with no jogada.

Test Plan:
- ADDR_WIDTH=2, TIMEOUT=10, modo=0. Reset, iniciar, then all 10 correct plays (rounds 0-3, i.e. 1+2+3+4) -> fim_acerto: acertou=1, pronto=1, rodada=3, endereco=3, db_estado=A.
- Rounds 0-1 correct; in round 2 the play at endereco=1 has igual=0 -> fim_erro: errou=1, rodada=2, endereco=1, db_estado=E.
- modo=1, idle in espera -> timeout=1 and db_estado=D exactly 10 cycles after entering espera.
- modo=1, jogada on the 10th cycle in espera (same edge as expiry) -> registra, not fim_timeout. Timer restarts after proximo.
- From fim_erro, iniciar -> preparacao then inicia_rodada: endereco=0, rodada=0, zeraR pulses. Also: jogada while in registra is ignored.
- reset=0 asynchronously mid-espera in round 2 -> outputs return to reset values before the next clock edge: db_estado=0, rodada=0, endereco=0.

Source files
------------

// File: rtl/unidade_controle_rodadas_if.sv
// Control bundle between the game top level (master) and the round control unit (slave).
// Carries the player/datapath inputs and the decoded controller outputs.
interface unidade_controle_rodadas_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  iniciar;
  logic                  jogada;
  logic                  igual;
  logic                  modo;
  logic                  zeraR;
  logic                  registraR;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [ADDR_WIDTH-1:0] rodada;
  logic                  acertou;
  logic                  errou;
  logic                  timeout;
  logic                  pronto;
  logic [3:0]            db_estado;

  modport master (
    output iniciar, jogada, igual, modo,
    input  zeraR, registraR, endereco, rodada, acertou, errou, timeout, pronto, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, modo,
    output zeraR, registraR, endereco, rodada, acertou, errou, timeout, pronto, db_estado
  );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// Round controller for the growing-sequence game: round k needs plays at addresses 0..k.
// Owns address/round counters and an optional inactivity timer; outputs are Moore-decoded.
//
// state          | meaning
// inicial        | idle after reset, waiting for iniciar
// preparacao     | clear counters and play register
// inicia_rodada  | rewind address for a new round
// espera         | waiting for a play (timer runs when modo=1)
// registra       | load play register
// comparacao     | judge play against memory
// proximo        | advance to next address in round
// proxima_rodada | advance to next round
// fim_acerto     | game won
// fim_erro       | wrong play
// fim_timeout    | inactivity expiry
module unidade_controle_rodadas #(
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT     = 3000,
  parameter int TIMER_WIDTH = 12
) (
  input logic clock,
  input logic reset,
  unidade_controle_rodadas_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_FIM = TIMER_WIDTH'(TIMEOUT - 1);

  estado_t               estado, estado_prox;
  logic [ADDR_WIDTH-1:0] endereco, rodada;
  logic [TIMER_WIDTH-1:0] timer;
  logic                  expirou;

  assign expirou      = bus.modo && (timer == TIMER_FIM);
  assign bus.endereco = endereco;
  assign bus.rodada   = rodada;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= '0;
      rodada   <= '0;
      timer    <= '0;
    end else begin
      case (estado)
        PREPARACAO: begin
          endereco <= '0;
          rodada   <= '0;
        end
        INICIA_RODADA: begin
          endereco <= '0;
          timer    <= '0;
        end
        ESPERA: begin
          // dropping modo freezes the count rather than clearing it
          if (bus.jogada)                   timer <= '0;
          else if (bus.modo && !expirou)    timer <= timer + 1'b1;
        end
        PROXIMO: begin
          endereco <= endereco + 1'b1;
          timer    <= '0;
        end
        PROXIMA_RODADA: rodada <= rodada + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    estado_prox   = estado;
    bus.zeraR     = 1'b0;
    bus.registraR = 1'b0;
    bus.acertou   = 1'b0;
    bus.errou     = 1'b0;
    bus.timeout   = 1'b0;
    bus.pronto    = 1'b0;
    bus.db_estado = estado;
    case (estado)
      INICIAL: begin
        bus.zeraR = 1'b1;
        if (bus.iniciar) estado_prox = PREPARACAO;
      end
      PREPARACAO: begin
        bus.zeraR   = 1'b1;
        estado_prox = INICIA_RODADA;
      end
      INICIA_RODADA: estado_prox = ESPERA;
      ESPERA: begin
        if (bus.jogada)  estado_prox = REGISTRA;
        else if (expirou) estado_prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        bus.registraR = 1'b1;
        estado_prox   = COMPARACAO;
      end
      COMPARACAO: begin
        if (!bus.igual)              estado_prox = FIM_ERRO;
        else if (endereco != rodada) estado_prox = PROXIMO;
        else if (rodada != '1)       estado_prox = PROXIMA_RODADA;
        else                         estado_prox = FIM_ACERTO;
      end
      PROXIMO:        estado_prox = ESPERA;
      PROXIMA_RODADA: estado_prox = INICIA_RODADA;
      FIM_ACERTO: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
        if (bus.iniciar) estado_prox = PREPARACAO;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
        if (bus.iniciar) estado_prox = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        bus.pronto  = 1'b1;
        bus.timeout = 1'b1;
        if (bus.iniciar) estado_prox = PREPARACAO;
      end
      default: begin
        bus.db_estado = 4'hF;
        estado_prox   = INICIAL;
      end
    endcase
  end

endmodule
